// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared 8N1 UART constants and receiver state type
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int       OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] LAST_TICK = 4'd15;
  localparam int       DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - divide-by-DIV oversample tick with synchronous phase clear
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampling 8N1 UART receiver with framing-error detect
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_ERR
);

  import uart_pkg::*;

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t  r_state, w_state_next;
  logic       r_rx_meta, r_rx_s;
  logic [3:0] r_tick_idx, w_tick_idx_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic [7:0] r_shift, w_shift_next;
  logic [7:0] r_data, w_data_next;
  logic       r_status, w_status_next;
  logic       r_err, w_err_next;
  logic       w_clear;
  logic       w_tick;

  assign RX_DATA   = r_data;
  assign RX_STATUS = r_status;
  assign RX_ERR    = r_err;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_state    <= IDLE;
      r_tick_idx <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_status   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_meta  <= UART_RX;
      r_rx_s     <= r_rx_meta;
      r_state    <= w_state_next;
      r_tick_idx <= w_tick_idx_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_data     <= w_data_next;
      r_status   <= w_status_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tick_idx_next = r_tick_idx;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_data_next     = r_data;
    w_status_next   = 1'b0;
    w_err_next      = 1'b0;
    w_clear         = 1'b0;

    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_clear         = 1'b1;
          w_tick_idx_next = '0;
          w_state_next    = START;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_tick_idx == MID_TICK) begin
            // A line back high at mid start bit was a glitch, not a frame.
            if (r_rx_s) begin
              w_state_next = IDLE;
            end else begin
              w_tick_idx_next = '0;
              w_bit_cnt_next  = '0;
              w_state_next    = DATA;
            end
          end else begin
            w_tick_idx_next = r_tick_idx + 4'd1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          w_tick_idx_next = r_tick_idx + 4'd1;
          if (r_tick_idx == LAST_TICK) begin
            w_shift_next[r_bit_cnt] = r_rx_s;
            if (r_bit_cnt == LAST_BIT) begin
              w_state_next = STOP;
            end else begin
              w_bit_cnt_next = r_bit_cnt + 3'd1;
            end
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_tick_idx_next = r_tick_idx + 4'd1;
          if (r_tick_idx == LAST_TICK) begin
            if (r_rx_s) begin
              w_data_next   = r_shift;
              w_status_next = 1'b1;
              w_state_next  = IDLE;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line idles so a break is not seen as 0x00 frames.
        if (r_rx_s) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver at a scaled baud (DIV=4, 64 clk/bit)
module tb_uart_receiver;

  localparam int BIT  = 64;
  localparam int FAST = 62;
  localparam int SLOW = 66;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       RX_ERR;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_pulse = 0;

  uart_receiver #(
    .CLK_FREQ   (640_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS),
    .RX_ERR    (RX_ERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input bit is_err, input logic [7:0] data, input int gap);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.gap    = gap;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bt, input int stop_low_bits);
    UART_RX = 1'b0;
    hold(bt);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      hold(bt);
    end
    if (stop_low_bits > 0) begin
      UART_RX = 1'b0;
      hold(stop_low_bits * bt);
    end
    UART_RX = 1'b1;
    hold(bt);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (RX_STATUS || RX_ERR) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse: got status=%0b err=%0b data=%0h, expected no pulse",
                 RX_STATUS, RX_ERR, RX_DATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_status", 32'(RX_STATUS), 32'(!e.is_err));
        check("pulse_err", 32'(RX_ERR), 32'(e.is_err));
        check("rx_data", 32'(RX_DATA), 32'(e.data));
        if (e.gap != 0) check("pulse_gap", 32'(cyc - last_pulse), 32'(e.gap));
      end
      last_pulse = cyc;
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got cycle budget exhausted, expected finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    UART_RX = 1'b1;
    hold(4);
    check("reset_data", 32'(RX_DATA), 32'h00);
    check("reset_status", 32'(RX_STATUS), 32'h0);
    check("reset_err", 32'(RX_ERR), 32'h0);
    reset = 1'b1;
    hold(2 * BIT);

    expect_ev(1'b0, 8'h55, 0);
    send_frame(8'h55, BIT, 0);
    hold(2 * BIT);

    expect_ev(1'b0, 8'hFF, 0);
    expect_ev(1'b0, 8'h00, 10 * BIT);
    send_frame(8'hFF, BIT, 0);
    send_frame(8'h00, BIT, 0);
    hold(2 * BIT);

    UART_RX = 1'b0;
    hold(12);
    UART_RX = 1'b1;
    hold(2 * BIT);
    expect_ev(1'b0, 8'hA3, 0);
    send_frame(8'hA3, BIT, 0);
    hold(2 * BIT);

    expect_ev(1'b1, 8'hA3, 0);
    send_frame(8'hA5, BIT, 3);
    hold(2 * BIT);
    expect_ev(1'b0, 8'h3C, 0);
    send_frame(8'h3C, BIT, 0);
    hold(2 * BIT);

    UART_RX = 1'b0;
    hold(BIT);
    for (int i = 0; i < 4; i++) begin
      UART_RX = 1'(8'h6E >> i);
      hold(BIT);
    end
    UART_RX = 1'b0;
    hold(BIT / 2);
    #2 reset = 1'b0;
    #1;
    check("midframe_reset_data", 32'(RX_DATA), 32'h00);
    check("midframe_reset_status", 32'(RX_STATUS), 32'h0);
    check("midframe_reset_err", 32'(RX_ERR), 32'h0);
    hold(4);
    UART_RX = 1'b1;
    hold(2);
    reset = 1'b1;
    hold(2 * BIT);
    expect_ev(1'b0, 8'h81, 0);
    send_frame(8'h81, BIT, 0);
    hold(2 * BIT);

    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 256; v += 17) begin
        expect_ev(1'b0, 8'(v), 0);
        send_frame(8'(v), (r == 0) ? FAST : SLOW, 0);
        hold(BIT);
      end
    end

    hold(4 * BIT);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
